// File: rtl/cpu_pkg.sv
// Shared encodings for the decode/sequencing stage: opcodes, datapath select
// codes, condition codes and the sequencing FSM state type.
package cpu_pkg;

  // instr[27:26]
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Data-processing command field, funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // alu_control
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // imm_src
  localparam logic [1:0] IMM_8   = 2'b00;
  localparam logic [1:0] IMM_12  = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // reg_src: bit0 -> R15 on read port 1, bit1 -> rd on read port 2
  localparam logic [1:0] RSRC_NONE = 2'b00;
  localparam logic [1:0] RSRC_PC   = 2'b01;
  localparam logic [1:0] RSRC_RD   = 2'b10;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Sequencing FSM
  typedef enum logic {
    S_EXEC = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against the NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Evaluate the condition field; 1111 never executes
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decode and sequencing for the single-cycle datapath: decodes the
// instruction fields, gates strobes by the condition code, keeps the NZCV
// flags, and stalls the PC on loads/stores until memory acks or times out.
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic       branch,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic       mem_req,
  output logic [3:0] flags,
  output logic       mem_err,
  output logic       undef
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic             cond_ex;

  // Decoded intent, before condition gating and sequencing
  logic       dp_write;
  logic       dp_arith;
  logic       is_dp, is_mem, is_ldr, is_str;
  logic       flag_upd;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign is_dp  = (op == OP_DP);
  assign is_mem = (op == OP_MEM);
  assign is_ldr = is_mem & funct[0];
  assign is_str = is_mem & ~funct[0];

  // Static field decode: datapath selects and ALU operation
  always_comb begin
    alu_src     = 1'b0;
    imm_src     = IMM_8;
    reg_src     = RSRC_NONE;
    alu_control = ALU_ADD;
    branch      = 1'b0;
    mem_to_reg  = 1'b0;
    dp_write    = 1'b0;
    dp_arith    = 1'b0;
    unique case (op)
      OP_DP: begin
        alu_src = funct[5];
        unique case (funct[4:1])
          CMD_ADD: begin alu_control = ALU_ADD; dp_write = 1'b1; dp_arith = 1'b1; end
          CMD_SUB: begin alu_control = ALU_SUB; dp_write = 1'b1; dp_arith = 1'b1; end
          CMD_AND: begin alu_control = ALU_AND; dp_write = 1'b1; end
          CMD_ORR: begin alu_control = ALU_ORR; dp_write = 1'b1; end
          CMD_CMP: begin alu_control = ALU_SUB; dp_arith = 1'b1; end
          default: alu_control = ALU_ADD;
        endcase
      end
      OP_MEM: begin
        alu_src    = 1'b1;
        imm_src    = IMM_12;
        reg_src    = funct[0] ? RSRC_NONE : RSRC_RD;
        mem_to_reg = funct[0];
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM_BR;
        reg_src = RSRC_PC;
      end
      default: ;
    endcase
  end

  // Sequencing FSM: next state, wait counter and gated strobes
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pc_en     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_req   = 1'b0;
    mem_err   = 1'b0;
    undef     = 1'b0;
    flag_upd  = 1'b0;
    unique case (state)
      S_EXEC: begin
        undef = (op == OP_UNDEF);
        if (is_mem && cond_ex) begin
          mem_req   = 1'b1;
          mem_write = is_str;
          if (mem_ack) begin
            pc_en     = 1'b1;
            reg_write = is_ldr;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = CNT_W'(1);
          end
        end else begin
          pc_en     = 1'b1;
          reg_write = is_dp & dp_write & cond_ex;
          flag_upd  = is_dp & funct[0] & cond_ex;
        end
      end
      S_WAIT: begin
        mem_req   = 1'b1;
        mem_write = is_str;
        if (mem_ack) begin
          pc_en     = 1'b1;
          reg_write = is_ldr;
          state_nxt = S_EXEC;
          wcnt_nxt  = '0;
        end else if (wcnt == CNT_MAX) begin
          mem_err   = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_EXEC;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt  = wcnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_EXEC;
    endcase
    if (reset) begin
      pc_en     = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
      mem_err   = 1'b0;
      undef     = 1'b0;
      flag_upd  = 1'b0;
    end
  end

  // PC redirect on taken branch or a write to R15 (reg_write already cond-gated)
  assign pc_src = cond_ex & (branch | (reg_write & (rd == 4'd15)));

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_EXEC;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // NZCV register: N,Z on any flag-setting op, C,V only for ADD/SUB/CMP
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (flag_upd) begin
      flags[3:2] <= alu_flags[3:2];
      if (dp_arith) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-decode and sequencing stage that drives the single-cycle `data_path`. It consumes the `cond`, `op`, `funct` and `rd` fields and the ALU flags that `data_path` exports, and evaluates ARM condition codes against a registered NZCV flags register. It produces every datapath control strobe and stalls the PC during a load or store until data memory acknowledges, aborting the access on timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: maximum memory-wait cycles before abort (≥1).

Ports (clock and reset first):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cond` in 4: instr[31:28].
- `op` in 2: instr[27:26].
- `funct` in 6: instr[25:20]; bit5 = I, bit0 = S or L.
- `rd` in 4: instr[15:12].
- `alu_flags` in 4: {N,Z,C,V} from the ALU.
- `mem_ack` in 1: data-memory completion.
- `pc_en` out 1: PC may advance (instruction retires).
- `pc_src`, `reg_write`, `mem_to_reg`, `mem_write`, `alu_src`, `branch` out 1 each: datapath strobes.
- `alu_control` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `imm_src` out 2: 00 imm8, 01 imm12, 10 branch offset.
- `reg_src` out 2: bit0 selects R15 as read address 1; bit1 selects rd as read address 2.
- `mem_req` out 1: memory access in progress.
- `flags` out 4: registered NZCV.
- `mem_err` out 1: one-cycle pulse on timeout abort.
- `undef` out 1: op = 11 decoded this cycle.

## Operation
Decode rules:
- **op 00 (data processing)**
  - `alu_src` = funct[5], `imm_src` = 00, `reg_src` = 00.
  - funct[4:1] selects the operation: 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - 1010 (CMP) → SUB with no register write.
  - Any other funct[4:1] → ADD with no register write.
- **op 01 (memory)**
  - Common: `alu_src` = 1, `imm_src` = 01, `alu_control` = ADD.
  - L = 0 (STR): `reg_src` = 10.
  - L = 1 (LDR): `mem_to_reg` = 1.
- **op 10 (branch)**: `branch` = 1, `alu_src` = 1, `imm_src` = 10, `reg_src` = 01, ADD.
- **op 11**: `undef` = 1; all write enables 0; retire as a no-op.

Condition evaluation (`cond_ex`) against `flags`:
- Codes 0000–1101: standard EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
- 1110 AL → always true.
- 1111 → false.

Gating and flag update:
- `pc_src` = `cond_ex` & (`branch` | (`reg_write` & `rd` == 15)).
- `reg_write`, `mem_write` and the flag update all require `cond_ex`.
- Flags update only in the retire cycle, only if S = 1 (op 00) and `cond_ex`:
  - N and Z always update.
  - C and V update only for ADD, SUB or CMP.

FSM states EXEC and WAIT; a wait counter `wcnt` counts memory-wait cycles.
- **EXEC**
  - Non-memory instruction, or memory instruction with `cond_ex` = 0: `pc_en` = 1 and the instruction retires this cycle.
  - Memory instruction with `cond_ex` = 1: `mem_req` = 1, and `mem_write` = 1 for STR.
  - If `mem_ack` = 1 in the same cycle: retire (`pc_en` = 1; `reg_write` = 1 for LDR).
  - Otherwise go to WAIT with `wcnt` = 1.
- **WAIT**
  - `mem_req` and `mem_write` (STR) stay held; `pc_en` = 0.
  - Inputs are stable because the PC is held.
  - On `mem_ack`: retire and return to EXEC.
  - If `wcnt` == `MEM_TIMEOUT` and no ack: `mem_err` = 1, `pc_en` = 1, no `reg_write`, return to EXEC.
  - Otherwise `wcnt` increments.

Boundaries and reset:
- `mem_ack` arriving in the same cycle as the timeout: the ack wins and no error is raised.
- `mem_ack` while not requesting: ignored.
- While `reset` = 1: `pc_en`, `reg_write`, `mem_write`, `mem_req`, `mem_err` and `undef` are forced to 0.
- Next state after reset is EXEC; `flags` = 0000; `wcnt` = 0.
- Reset during WAIT drops `mem_req` immediately and abandons the access.

## Timing
- All strobes are combinational from the decode inputs and the current state.
- Non-memory instructions: 1 cycle.
- Memory instructions: 1 + k cycles, where k = number of cycles until ack; maximum 1 + `MEM_TIMEOUT`.
- `flags` is visible to the next instruction (1-cycle latency).
- `mem_err` lasts exactly one cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - op encodings;
  - `alu_control` codes;
  - `imm_src` and `reg_src` codes;
  - condition-code constants;
  - the FSM state enum.
- Sub-module `cond_check` is purely combinational: (`cond`, `flags`) → `cond_ex`.
- `control_unit` holds the decoder, the flags register, the FSM and the wait counter.

## Test plan
- ADDS R1 (cond 1110, op 00, funct 001001), `alu_flags` = 0100 → `reg_write` = 1, `pc_en` = 1, `flags` = 0100 next cycle.
- CMP (funct 010101), then BEQ (cond 0000, op 10), with `alu_flags` Z = 1 → CMP: `reg_write` = 0; BEQ: `pc_src` = 1. Repeat with Z = 0 → `pc_src` = 0.
- LDR with `mem_ack` after 3 cycles → `mem_req` high for 4 cycles, `pc_en` low for 3 cycles, `reg_write` and `pc_en` high on the ack cycle.
- STR with no ack, `MEM_TIMEOUT` = 4 → `mem_write` and `mem_req` high for 5 cycles, `mem_err` pulses on cycle 5 with `pc_en` = 1, then back to EXEC.
- Data-processing write with rd = 15 → `pc_src` = 1. With cond = 1111 → no writes, `pc_en` = 1. With op = 11 → `undef` = 1.
- Reset asserted on the second WAIT cycle → `mem_req` = 0 that cycle, `flags` = 0000, next instruction handled in EXEC.
